hamming_dec_pipe: RTL and testbench

//  Parametrised Hamming(2^R-1, 2^R-1-R) receive-side decoder: computes syndrome, corrects single-bit errors.
//  2-stage registered pipeline, valid/ready on both sides, saturating error counters.

---
 rtl/hamming_dec_pipe.sv | 104 ++++++++++
 tb/tb_hamming_dec_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hamming_dec_pipe.sv
// hamming_dec_pipe: 2-stage Hamming SEC decoder with saturating counters; define HAMMING_SECDED_EN for SECDED via in_pext
module hamming_dec_pipe #(
  parameter int R = 3,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**R-2:0]   in_code,
`ifdef HAMMING_SECDED_EN
  input  logic              in_pext,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**R-R-2:0] out_data,
  output logic [R-1:0]      out_syn,
  output logic              out_err,
  output logic              out_uncorr,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);
  localparam int N = 2**R-1;
  localparam int K = N-R;
  logic started, s1_valid, s1_par, par, fix, uncorr, s2_can_load, xfer;
  logic [N-1:0] s1_code;
  logic [R-1:0] syn, s1_syn;
  logic [K-1:0] data;
  assign s2_can_load = !out_valid || out_ready;
  assign in_ready = started && (!s1_valid || s2_can_load);
  assign xfer = out_valid && out_ready;
  always_comb begin
    syn = '0;
    for (int p = 1; p <= N; p++) syn ^= in_code[p-1] ? R'(p) : R'(0);
  end
`ifdef HAMMING_SECDED_EN
  assign par = ^in_code ^ in_pext;
  assign uncorr = (s1_syn != '0) && !s1_par;
`else
  assign par = syn != '0;
  assign uncorr = 1'b0;
`endif
  assign fix = (s1_syn != '0) && s1_par;
  always_comb begin
    int j;
    j = 0;
    data = '0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p-1)) != 0) begin
        data[j] = s1_code[p-1] ^ (fix && s1_syn == R'(p));
        j++;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started <= 1'b0;
      s1_valid <= 1'b0;
      s1_code <= '0;
      s1_syn <= '0;
      s1_par <= 1'b0;
    end else begin
      started <= 1'b1;
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_code <= in_code;
          s1_syn <= syn;
          s1_par <= par;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_syn <= '0;
      out_err <= 1'b0;
      out_uncorr <= 1'b0;
    end else if (s2_can_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= data;
        out_syn <= s1_syn;
        out_err <= s1_par;
        out_uncorr <= uncorr;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt <= '0;
      uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      corr_cnt <= '0;
      uncorr_cnt <= '0;
    end else begin
      if (xfer && out_err && !(&corr_cnt)) corr_cnt <= corr_cnt + CNT_W'(1);
      if (xfer && out_uncorr && !(&uncorr_cnt)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hamming_dec_pipe.sv
// tb_hamming_dec_pipe: scoreboard bench for hamming_dec_pipe (R=3) in SEC or HAMMING_SECDED_EN builds
module tb_hamming_dec_pipe;
`ifdef HAMMING_SECDED_EN
  localparam bit SD = 1'b1;
`else
  localparam bit SD = 1'b0;
`endif
  typedef struct packed {logic [3:0] data; logic [2:0] syn; logic err; logic uncorr;} exp_t;
  typedef struct packed {logic [6:0] code; logic pext; exp_t e;} vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, in_pext = 0, out_ready = 1, clr_cnt = 0;
  logic [6:0] in_code = '0;
  logic in_ready, out_valid, out_err, out_uncorr;
  logic [3:0] out_data;
  logic [2:0] out_syn;
  logic [15:0] corr_cnt, uncorr_cnt;
  logic s_valid = 0, s_clr = 0, s_oready = 1;
  logic [6:0] s_code = '0;
  logic s_in_ready, s_out_valid, s_out_err, s_out_uncorr;
  logic [3:0] s_out_data;
  logic [2:0] s_out_syn;
  logic [1:0] s_corr, s_uncorr;
  int errors = 0, checks = 0, exp_corr = 0, exp_uncorr = 0;
  exp_t sb[$];
  vec_t vec[10];
  always #5 clk = ~clk;
  hamming_dec_pipe #(.R(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
`ifdef HAMMING_SECDED_EN
    .in_pext(in_pext),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_syn(out_syn),
    .out_err(out_err), .out_uncorr(out_uncorr), .clr_cnt(clr_cnt), .corr_cnt(corr_cnt),
    .uncorr_cnt(uncorr_cnt)
  );
  hamming_dec_pipe #(.R(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_in_ready), .in_code(s_code),
`ifdef HAMMING_SECDED_EN
    .in_pext(1'b0),
`endif
    .out_valid(s_out_valid), .out_ready(s_oready), .out_data(s_out_data), .out_syn(s_out_syn),
    .out_err(s_out_err), .out_uncorr(s_out_uncorr), .clr_cnt(s_clr), .corr_cnt(s_corr),
    .uncorr_cnt(s_uncorr)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic send(input int i);
    int n = 0;
    in_code = vec[i].code;
    in_pext = vec[i].pext;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    chk("send_accept", in_ready, 1);
    @(posedge clk);
    sb.push_back(vec[i].e);
    exp_corr += vec[i].e.err ? 1 : 0;
    exp_uncorr += vec[i].e.uncorr ? 1 : 0;
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin : monitor
    logic held;
    exp_t hv, e;
    held = 1'b0;
    hv = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) held = 1'b0;
      else begin
        if (held) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_stable", {out_data, out_syn, out_err, out_uncorr}, hv);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_out", sb.size(), 1);
          else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_syn", out_syn, e.syn);
            chk("out_err", out_err, e.err);
            chk("out_uncorr", out_uncorr, e.uncorr);
          end
        end
        held = out_valid && !out_ready;
        hv = {out_data, out_syn, out_err, out_uncorr};
      end
    end
  end
  initial begin
    vec[0] = '{7'h55, 1'b0, '{4'b1011, 3'd0, 1'b0, 1'b0}};
    vec[1] = '{7'h45, 1'b0, '{4'b1011, 3'd5, 1'b1, 1'b0}};
    vec[2] = '{7'h44, 1'b0, '{4'b1001, 3'd4, !SD, SD}};
    vec[3] = '{7'h00, 1'b0, '{4'b0000, 3'd0, 1'b0, 1'b0}};
    vec[4] = '{7'h7f, 1'b1, '{4'b1111, 3'd0, 1'b0, 1'b0}};
    vec[5] = '{7'h55, 1'b1, '{4'b1011, 3'd0, SD, 1'b0}};
    vec[6] = '{7'h31, 1'b0, '{4'b0110, 3'd2, 1'b1, 1'b0}};
    vec[7] = '{7'h12, 1'b0, '{SD ? 4'b0010 : 4'b1010, 3'd7, !SD, SD}};
    vec[8] = '{7'h03, 1'b1, '{4'b0001, 3'd3, 1'b1, 1'b0}};
    vec[9] = '{7'h07, 1'b1, '{4'b0001, 3'd0, 1'b0, 1'b0}};
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", {out_data, out_syn, out_err, out_uncorr}, 0);
    chk("rst_cnts", {corr_cnt, uncorr_cnt}, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(0);
    drain();
    chk("corr_after_clean", corr_cnt, 0);
    send(1);
    drain();
    chk("corr_after_single", corr_cnt, 1);
    send(2);
    drain();
    chk("corr_after_pos4", corr_cnt, exp_corr);
    chk("uncorr_after_pos4", uncorr_cnt, exp_uncorr);
    fork
      for (int i = 0; i < 8; i++) send(i + 2);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("corr_total", corr_cnt, exp_corr);
    chk("uncorr_total", uncorr_cnt, exp_uncorr);
    @(posedge clk);
    #1 s_valid = 1'b1;
    s_code = 7'h45;
    repeat (5) @(posedge clk);
    #1 s_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sat_corr", s_corr, 3);
    @(posedge clk);
    #1 s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(posedge clk);
    #1 chk("sat_6th_valid", s_out_valid, 1);
    s_clr = 1'b1;
    @(posedge clk);
    #1 s_clr = 1'b0;
    chk("sat_clr_wins", s_corr, 0);
    out_ready = 1'b0;
    send(1);
    send(7);
    @(negedge clk);
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_cnts", {corr_cnt, uncorr_cnt}, 0);
    sb.delete();
    exp_corr = 0;
    exp_uncorr = 0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 0);
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(8);
    @(negedge clk);
    chk("lat_cycle1", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2", out_valid, 1);
    drain();
    chk("corr_post_rst", corr_cnt, exp_corr);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
